// File: rtl/nor4_bist_pkg.sv
// nor4_bist_pkg: shared types and constants for the nor4 BIST controller.
//   state_e    - controller state (IDLE / RUN / DONE)
//   ERR_W      - width of the mismatch counter
//   ERR_SAT    - value at which the mismatch counter stops counting
//   nor4_exp() - golden NOR4 response for a {A4,A3,A2,A1} vector
package nor4_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int             ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

    function automatic logic nor4_exp(input logic [3:0] vec);
        return ~|vec;
    endfunction

endpackage

// File: rtl/nor4_bist_acc.sv
// nor4_bist_acc: compare/accumulate stage of the nor4 BIST controller.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   clear_i         - clear all results (start of a new run)
//   sample_i        - compare strobe: zn_i is checked against vec_i this cycle
//   vec_i [3:0]     - vector currently applied, {A4,A3,A2,A1}
//   zn_i            - observed gate output
//   err_cnt_o [7:0] - saturating mismatch count
//   fail_valid_o    - at least one mismatch recorded since the last clear
//   fail_vec_o[3:0] - vector of the first mismatch
//   mismatch_o      - combinational: this strobe is a mismatch
module nor4_bist_acc
    import nor4_bist_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic [3:0]       vec_i,
    input  logic             zn_i,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_valid_o,
    output logic [3:0]       fail_vec_o,
    output logic             mismatch_o
);

    logic [ERR_W-1:0] err_q;
    logic             fvalid_q;
    logic [3:0]       fvec_q;

    // Case inequality so an X or Z on the observed pin counts as a failure
    // in simulation; in hardware it reduces to an ordinary compare.
    assign mismatch_o = sample_i && (zn_i !== nor4_exp(vec_i));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
        end else if (clear_i) begin
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
        end else if (mismatch_o) begin
            if (err_q != ERR_SAT) err_q <= err_q + 1'b1;
            if (!fvalid_q) begin
                fvalid_q <= 1'b1;
                fvec_q   <= vec_i;
            end
        end
    end

    assign err_cnt_o    = err_q;
    assign fail_valid_o = fvalid_q;
    assign fail_vec_o   = fvec_q;

endmodule

// File: rtl/nor4_bist_ctrl.sv
// nor4_bist_ctrl: BIST controller driving one nor4 cell under test.
// Sweeps all 16 {A4,A3,A2,A1} vectors PASSES times, holding each for SETTLE
// cycles and checking ZN_OBS against NOR4 on the last cycle of the hold.
// Ports:
//   CLK, RN        - clock, asynchronous active-low reset
//   START          - run request (honoured in IDLE or DONE only)
//   ZN_OBS         - observed gate output
//   A1..A4         - registered drive to the gate under test
//   BUSY, DONE     - run in progress / run complete (held until next START)
//   PASS           - DONE with zero mismatches
//   ERR_CNT [7:0]  - saturating mismatch count
//   FAIL_VALID     - a mismatch has been recorded this run
//   FAIL_VEC [3:0] - {A4,A3,A2,A1} of the first mismatch
//   VDD, VSS       - power pins, only with USE_POWER_PINS
module nor4_bist_ctrl
    import nor4_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ZN_OBS,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [3:0]       FAIL_VEC
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    state_e        state_q, state_d;
    logic [3:0]    vec_q, vec_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    a_q, a_d;
    logic          busy_q, done_q, ok_q, ok_d;

    logic          sample, last, clear, mismatch;

    // Compare on the final cycle of each hold; the run ends on the last
    // compare of the last pass.
    assign sample = (state_q == ST_RUN) && (settle_q == SETTLE_LAST);
    assign last   = sample && (vec_q == 4'hF) && (pcnt_q == PASS_LAST);

    nor4_bist_acc u_acc (
        .clk_i       (CLK),
        .rst_ni      (RN),
        .clear_i     (clear),
        .sample_i    (sample),
        .vec_i       (vec_q),
        .zn_i        (ZN_OBS),
        .err_cnt_o   (ERR_CNT),
        .fail_valid_o(FAIL_VALID),
        .fail_vec_o  (FAIL_VEC),
        .mismatch_o  (mismatch)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        pcnt_d   = pcnt_q;
        a_d      = a_q;
        ok_d     = ok_q;
        clear    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_RUN;
                    vec_d    = '0;
                    settle_d = '0;
                    pcnt_d   = '0;
                    a_d      = '0;
                    ok_d     = 1'b0;
                    clear    = 1'b1;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    settle_d = '0;
                    vec_d    = vec_q + 4'd1;
                    a_d      = vec_q + 4'd1;
                    if (vec_q == 4'hF) pcnt_d = pcnt_q + 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                        a_d     = '0;
                        pcnt_d  = '0;
                        // Include this final compare, which the counter has
                        // not absorbed yet.
                        ok_d    = (ERR_CNT == '0) && !mismatch;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            pcnt_q   <= '0;
            a_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            a_q      <= a_d;
            // Status flags are their own flops so outputs never decode the
            // encoded state combinationally.
            busy_q   <= (state_d == ST_RUN);
            done_q   <= (state_d == ST_DONE);
            ok_q     <= ok_d;
        end
    end

    assign {A4, A3, A2, A1} = a_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = done_q && ok_q;

endmodule

// File: tb/tb_nor4_bist_ctrl.sv
module tb_nor4_bist_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       zn;
    int         zmode = 0;

    logic       a1, a2, a3, a4, busy, done, pass, fvalid;
    logic [7:0] err;
    logic [3:0] fvec;

    logic       b1, b2, b3, b4, busy2, done2, pass2, fvalid2;
    logic [7:0] err2;
    logic [3:0] fvec2;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Gate-under-test models: 0 healthy, 1 stuck-0, 2 stuck-1, 3 ZN = ~A1.
    always_comb begin
        zn = 1'b0;
        case (zmode)
            0:       zn = ~(a1 | a2 | a3 | a4);
            1:       zn = 1'b0;
            2:       zn = 1'b1;
            default: zn = ~a1;
        endcase
    end

    nor4_bist_ctrl #(.SETTLE(SETTLE), .PASSES(1)) dut (
        .CLK(clk), .RN(rn), .START(start), .ZN_OBS(zn),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err),
        .FAIL_VALID(fvalid), .FAIL_VEC(fvec)
    );

    nor4_bist_ctrl #(.SETTLE(SETTLE), .PASSES(20)) dut2 (
        .CLK(clk), .RN(rn), .START(start2), .ZN_OBS(1'b1),
        .A1(b1), .A2(b2), .A3(b3), .A4(b4),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2),
        .FAIL_VALID(fvalid2), .FAIL_VEC(fvec2)
    );

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_fvalid;
        int    exp_fvec;
        int    exp_pass;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse START, then count BUSY cycles while checking that vector k sits
    // on A* for exactly SETTLE cycles. A second START pulse may be injected
    // at busy cycle glitch_at (negative = none).
    task automatic run_dut1(input int glitch_at, output int cyc, output int seq_bad);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        seq_bad = 0;
        while (busy && cyc < 2000) begin
            if ({a4, a3, a2, a1} != 4'((cyc / SETTLE) % 16)) seq_bad++;
            start = (cyc == glitch_at);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t tbl[4];
        int   cyc, bad;

        tbl[0] = '{"healthy",   0, 0,  0, 0, 1};
        tbl[1] = '{"stuck0",    1, 1,  1, 0, 0};
        tbl[2] = '{"stuck1",    2, 15, 1, 1, 0};
        tbl[3] = '{"zn_not_a1", 3, 7,  1, 2, 0};

        // Reset state.
        #2;
        check("rst_a",     int'({a4, a3, a2, a1}), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_pass",  int'(pass), 0);
        check("rst_err",   int'(err), 0);
        check("rst_fv",    int'(fvalid), 0);
        @(negedge clk) rn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Table-driven single-pass runs.
        for (int i = 0; i < 4; i++) begin
            zmode = tbl[i].mode;
            run_dut1(-1, cyc, bad);
            check({tbl[i].name, "_busy_cycles"}, cyc, 16 * SETTLE);
            check({tbl[i].name, "_vec_seq"},     bad, 0);
            check({tbl[i].name, "_done"},        int'(done), 1);
            check({tbl[i].name, "_a_idle"},      int'({a4, a3, a2, a1}), 0);
            check({tbl[i].name, "_err"},         int'(err), tbl[i].exp_err);
            check({tbl[i].name, "_fvalid"},      int'(fvalid), tbl[i].exp_fvalid);
            if (tbl[i].exp_fvalid != 0)
                check({tbl[i].name, "_fvec"},    int'(fvec), tbl[i].exp_fvec);
            check({tbl[i].name, "_pass"},        int'(pass), tbl[i].exp_pass);
        end

        // START during BUSY is ignored: length and results unchanged.
        zmode = 0;
        run_dut1(5, cyc, bad);
        check("glitch_busy_cycles", cyc, 16 * SETTLE);
        check("glitch_vec_seq",     bad, 0);
        check("glitch_pass",        int'(pass), 1);

        // START in DONE clears the previous failing results.
        zmode = 2;
        run_dut1(-1, cyc, bad);
        check("redo_prev_err", int'(err), 15);
        zmode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("redo_busy",   int'(busy), 1);
        check("redo_done",   int'(done), 0);
        check("redo_err",    int'(err), 0);
        check("redo_fvalid", int'(fvalid), 0);
        check("redo_pass",   int'(pass), 0);
        cyc = 0;
        while (!done && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("redo_final_pass", int'(pass), 1);

        // Reset mid-run: outputs drop immediately, without a clock edge.
        zmode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_err_before_rst", int'(err), 4);
        rn = 1'b0;
        #1;
        check("mid_rst_a",    int'({a4, a3, a2, a1}), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_pass", int'(pass), 0);
        check("mid_rst_err",  int'(err), 0);
        check("mid_rst_fv",   int'(fvalid), 0);
        check("mid_rst_fvec", int'(fvec), 0);
        @(negedge clk) rn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        // 20 passes with ZN stuck at 1: 300 mismatches saturate at 255.
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        cyc = 0;
        while (busy2 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        check("sat_busy_cycles", cyc, 16 * 20 * SETTLE);
        check("sat_done",        int'(done2), 1);
        check("sat_err",         int'(err2), 255);
        check("sat_fvec",        int'(fvec2), 1);
        check("sat_pass",        int'(pass2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/nor4_bist_ctrl.md
# nor4_bist_ctrl

Built-in self-test controller that exercises a `nor4` cell instance from the driving side. It sequences all 16 input vectors onto the gate's `A1`..`A4` pins and samples the gate's `ZN` output after a programmable settle delay. It compares each sample against the NOR4 truth table and reports the error count, the first failing vector and a pass flag. It sits beside library cells on silicon-validation and characterization test chips, with one controller per gate under test.

## Interface

Parameters:
- `SETTLE`, default 2: cycles each vector is held before `ZN` is sampled; legal range ≥1.
- `PASSES`, default 1: full 16-vector sweeps per run; legal range ≥1.

Ports:
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RN` in 1: reset, asynchronous and active-low.
- `START` in 1: run request, sampled only in IDLE or DONE.
- `ZN_OBS` in 1: observed output of the gate under test.
- `A1`,`A2`,`A3`,`A4` out 1 each: registered drive to the gate under test.
- `BUSY` out 1: run in progress.
- `DONE` out 1: run complete; held until the next accepted `START`.
- `PASS` out 1: `DONE && ERR_CNT==0`.
- `ERR_CNT` out 8: mismatch count, saturating at 255.
- `FAIL_VALID` out 1: at least one mismatch has been recorded this run.
- `FAIL_VEC` out 4: vector `{A4,A3,A2,A1}` of the first mismatch.
- `VDD`,`VSS` inout: present only under `USE_POWER_PINS`.

## Operation

- States: IDLE, RUN, DONE.
- IDLE → RUN when `START`=1. On entry:
  - vector counter `vec`=0, settle counter=0, pass counter=0.
  - `ERR_CNT`=0 and `FAIL_VALID`=0.
  - `A4..A1`=`vec`, with `A1`=`vec[0]`.
- RUN:
  - Settle counter increments each cycle.
  - When it reaches `SETTLE`-1, `ZN_OBS` is compared to expected `~|vec`.
  - On the same edge the counter returns to 0 and `vec` increments; the new vector drives `A*` from that edge.
  - Any mismatch, including an X/Z on `ZN_OBS`, increments `ERR_CNT`, saturating at 255.
  - On the first mismatch of a run, `FAIL_VEC`←`vec` and `FAIL_VALID`←1. Later mismatches leave `FAIL_VEC` unchanged.
  - When `vec` wraps from 15 to 0, the pass counter increments. After the final compare of pass `PASSES`-1, the state goes to DONE.
- DONE:
  - `A*`=0.
  - `DONE`=1, and results are frozen.
  - `START`=1 behaves exactly like the IDLE→RUN transition, clearing the results.
- `START` while in RUN is ignored.
- `BUSY`=1 exactly while in RUN.
- Reset (`RN`=0, any time, including mid-run) immediately forces IDLE:
  - `A*`=0, `BUSY`=0, `DONE`=0, `PASS`=0, `ERR_CNT`=0, `FAIL_VALID`=0, `FAIL_VEC`=0.
  - All counters=0.

## Timing

- `START` seen high at edge t:
  - `BUSY`=1 and vector 0 appear on `A*` after edge t.
  - Vector k is held for exactly `SETTLE` cycles.
  - The vector-k compare occurs at edge t+(k+1)·`SETTLE` within pass 0.
- Run length: `BUSY` is high for 16·`PASSES`·`SETTLE` cycles.
- The last compare and the assertion of `DONE` happen on the same edge. `ERR_CNT`, `FAIL_*` and `PASS` are valid with `DONE`.
- All outputs are registered. There is no combinational path from `ZN_OBS` or `START` to any output.
- `ZN_OBS` is sampled without a synchronizer: the gate under test is clocked by the same domain through `A*`. `SETTLE` must cover the gate delay plus routing.

## Structure

- Package `nor4_bist_pkg` contains:
  - the state enum (IDLE/RUN/DONE);
  - the `ERR_CNT` width constant (8) and saturation value (255);
  - function `nor4_exp(vec)` returning `~|vec`.
- Sub-module `nor4_bist_acc` is the compare/accumulate stage. Its inputs are a sample strobe, `vec`, `ZN_OBS` and a clear. Its outputs are `ERR_CNT`, `FAIL_VALID` and `FAIL_VEC`.
- The top level holds the FSM, the settle/vector/pass counters and the `A*` drive registers.

## Test plan

- Healthy `nor4` behavioural model on `A*`/`ZN_OBS`, `SETTLE`=2, `PASSES`=1, `START` pulse → `BUSY` high 32 cycles, then `DONE`=1, `PASS`=1, `ERR_CNT`=0, `FAIL_VALID`=0.
- `ZN_OBS` stuck at 0 → `ERR_CNT`=1, `FAIL_VEC`=0, `PASS`=0.
- `ZN_OBS` stuck at 1 → `ERR_CNT`=15, `FAIL_VEC`=1.
- `ZN_OBS`=~`A1` → mismatches at vectors 2,4,…,14 → `ERR_CNT`=7, `FAIL_VEC`=2.
- `ZN_OBS` stuck at 1, `PASSES`=20 → 300 mismatches → `ERR_CNT`=255 (saturated).
- `RN` low at cycle 10 of a run → all outputs 0 immediately. `START` asserted during `BUSY` → no restart, and cycle count unchanged. `START` in DONE → results cleared, new run begins.
